// File: rtl/dp_pkg.sv
// Shared encodings for the register data path: ALU opcodes, bus sources,
// memory FSM states and the condition-code layout.
package dp_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NOTA = 3'd5,
        ALU_INCA = 3'd6,
        ALU_PASB = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        BUS_ALU = 2'd0,
        BUS_RF  = 2'd1,
        BUS_MDR = 2'd2,
        BUS_PC  = 2'd3
    } bus_sel_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: eight operations on A/B with N/Z/V/C flag generation.
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output flags_t            flags_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   sum_add;
    logic [DATA_W:0]   sum_sub;
    logic [DATA_W:0]   sum_inc;
    logic [DATA_W-1:0] res;
    logic              v;
    logic              c;

    // The extra top bit carries out of ADD/INC and reads as borrow for SUB.
    assign sum_add = {1'b0, a_i} + {1'b0, b_i};
    assign sum_sub = {1'b0, a_i} - {1'b0, b_i};
    assign sum_inc = {1'b0, a_i} + (DATA_W+1)'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        res = '0;
        v   = 1'b0;
        c   = 1'b0;
        case (op_i)
            ALU_ADD: begin
                res = sum_add[DATA_W-1:0];
                c   = sum_add[DATA_W];
                v   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                res = sum_sub[DATA_W-1:0];
                c   = sum_sub[DATA_W];
                v   = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_AND:  res = a_i & b_i;
            ALU_OR:   res = a_i | b_i;
            ALU_XOR:  res = a_i ^ b_i;
            ALU_NOTA: res = ~a_i;
            ALU_INCA: begin
                res = sum_inc[DATA_W-1:0];
                c   = sum_inc[DATA_W];
                v   = !a_i[MSB] && res[MSB];
            end
            ALU_PASB: res = b_i;
            default:  res = '0;
        endcase
    end

    assign result_o = res;
    assign flags_o  = '{n: res[MSB], z: (res == '0), v: v, c: c};

endmodule

// File: rtl/reg_data_path.sv
// Register data path: register file, IR/PC/MAR/MDR/CCR around a shared bus,
// plus a two-state memory handshake FSM that freezes the path while busy.
module reg_data_path
    import dp_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 8,
    parameter  int NREGS  = 4,
    localparam int RS_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_load,
    input  logic              ccr_load,
    input  logic              mar_load,
    input  logic              pc_load,
    input  logic              pc_inc,
    input  logic              rf_we,
    input  logic [RS_W-1:0]   rf_wsel,
    input  logic [RS_W-1:0]   rf_asel,
    input  logic [RS_W-1:0]   rf_bsel,
    input  logic [RS_W-1:0]   out_sel,
    input  logic [2:0]        alu_sel,
    input  logic [1:0]        bus_sel,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        ccr
);

    mem_state_e        state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] ir_q, mdr_q, mem_wdata_q;
    logic [ADDR_W-1:0] mar_q, pc_q, mem_addr_q;
    logic              mem_we_q;
    flags_t            ccr_q;

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_res;
    flags_t            alu_flags;
    logic              idle;
    logic              start;

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (alu_op_e'(alu_sel)),
        .a_i      (rf_q[rf_asel]),
        .b_i      (rf_q[rf_bsel]),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    always_comb begin
        bus = '0;
        case (bus_sel_e'(bus_sel))
            BUS_ALU: bus = alu_res;
            BUS_RF:  bus = rf_q[out_sel];
            BUS_MDR: bus = mdr_q;
            BUS_PC:  bus = DATA_W'(pc_q);
            default: bus = '0;
        endcase
    end

    // Every strobe is qualified by idle so nothing moves during an access.
    assign idle  = (state_q == ST_IDLE);
    assign start = idle && (mem_rd || mem_wr);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)   state_d = ST_ACCESS;
            ST_ACCESS: if (mem_ack) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q        <= '0;
            mar_q       <= '0;
            pc_q        <= '0;
            mdr_q       <= '0;
            ccr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            // NOTE: the register file is flops, not RAM, and must read zero after reset, so each entry is cleared.
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            if (idle && ir_load)  ir_q  <= bus;
            if (idle && mar_load) mar_q <= ADDR_W'(bus);
            if (idle && ccr_load) ccr_q <= alu_flags;
            if (idle && rf_we)    rf_q[rf_wsel] <= bus;
            if (idle && pc_load)     pc_q <= ADDR_W'(bus);
            else if (idle && pc_inc) pc_q <= pc_q + ADDR_W'(1);

            // A simultaneous rd+wr latches mem_we high, so it runs as a write.
            if (start) begin
                mem_addr_q  <= mar_q;
                mem_wdata_q <= rf_q[out_sel];
                mem_we_q    <= mem_wr;
            end
            if (!idle && mem_ack && !mem_we_q) mdr_q <= mem_rdata;
        end
    end

    assign mem_req   = !idle;
    assign busy      = !idle;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ir        = ir_q;
    assign ccr       = ccr_q;

endmodule

// File: tb/tb_reg_data_path.sv
// Directed bench for reg_data_path: ALU/flags, PC wrap and priority,
// memory handshake, busy gating and reset abort.
module tb_reg_data_path;

    logic       clk = 1'b0;
    logic       reset;
    logic       ir_load, ccr_load, mar_load, pc_load, pc_inc, rf_we;
    logic [1:0] rf_wsel, rf_asel, rf_bsel, out_sel;
    logic [2:0] alu_sel;
    logic [1:0] bus_sel;
    logic       mem_rd, mem_wr;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack;
    logic       busy;
    logic [7:0] ir;
    logic [3:0] ccr;

    int checks = 0;
    int errors = 0;

    reg_data_path dut (
        .clk       (clk),
        .reset     (reset),
        .ir_load   (ir_load),
        .ccr_load  (ccr_load),
        .mar_load  (mar_load),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .rf_asel   (rf_asel),
        .rf_bsel   (rf_bsel),
        .out_sel   (out_sel),
        .alu_sel   (alu_sel),
        .bus_sel   (bus_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .ir        (ir),
        .ccr       (ccr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        ir_load = 0; ccr_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0;
        rf_we = 0; mem_rd = 0; mem_wr = 0; mem_ack = 0;
    endtask

    task automatic mem_read(input logic [7:0] val);
        mem_rd = 1; tick(); mem_rd = 0;
        mem_ack = 1; mem_rdata = val; tick(); mem_ack = 0;
    endtask

    task automatic load_rf(input logic [1:0] idx, input logic [7:0] val);
        mem_read(val);
        bus_sel = 2'd2; rf_wsel = idx; rf_we = 1; tick(); rf_we = 0;
    endtask

    // Copies a bus source into IR so internal registers become visible.
    task automatic peek(input string tag, input logic [1:0] sel, input logic [1:0] osel,
                        input logic [7:0] expected);
        bus_sel = sel; out_sel = osel; ir_load = 1; tick(); ir_load = 0;
        check(tag, ir, expected);
    endtask

    task automatic alu_step(input string tag, input logic [2:0] op,
                            input logic [7:0] exp_res, input logic [3:0] exp_ccr);
        alu_sel = op; rf_asel = 2'd0; rf_bsel = 2'd1; bus_sel = 2'd0;
        ir_load = 1; ccr_load = 1; tick(); ir_load = 0; ccr_load = 0;
        check({tag, "_res"}, ir, exp_res);
        check({tag, "_ccr"}, ccr, exp_ccr);
    endtask

    logic [7:0] op_res [8] = '{8'h2C, 8'hB4, 8'h30, 8'hFC, 8'hCC, 8'h0F, 8'hF1, 8'h3C};
    logic [3:0] op_ccr [8] = '{4'b0001, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000};

    initial begin
        clear_strobes();
        reset = 1; mem_rdata = 8'h00;
        rf_wsel = 0; rf_asel = 0; rf_bsel = 0; out_sel = 0; alu_sel = 0; bus_sel = 0;
        repeat (2) tick();
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ir", ir, 0);
        check("rst_ccr", ccr, 0);
        reset = 0;
        tick();

        // Signed overflow on ADD, then INC of 0x7F.
        load_rf(0, 8'h7F); load_rf(1, 8'h01);
        alu_step("add_ovf", 3'd0, 8'h80, 4'b1010);
        alu_step("inc_ovf", 3'd6, 8'h80, 4'b1010);

        // SUB with borrow, then equal operands.
        load_rf(0, 8'h05); load_rf(1, 8'h07);
        alu_step("sub_borrow", 3'd1, 8'hFE, 4'b1001);
        load_rf(0, 8'h33); load_rf(1, 8'h33);
        alu_step("sub_zero", 3'd1, 8'h00, 4'b0100);

        load_rf(0, 8'hF0); load_rf(1, 8'h3C);
        for (int op = 0; op < 8; op++)
            alu_step($sformatf("op%0d", op), 3'(op), op_res[op], op_ccr[op]);

        // PC wrap and pc_load priority over pc_inc.
        load_rf(2, 8'hFF);
        bus_sel = 2'd1; out_sel = 2'd2; pc_load = 1; tick(); pc_load = 0;
        peek("pc_ff", 2'd3, 2'd2, 8'hFF);
        pc_inc = 1; tick(); pc_inc = 0;
        peek("pc_wrap", 2'd3, 2'd2, 8'h00);
        load_rf(2, 8'h40);
        bus_sel = 2'd1; out_sel = 2'd2; pc_load = 1; pc_inc = 1; tick(); clear_strobes();
        peek("pc_load_wins", 2'd3, 2'd2, 8'h40);
        pc_inc = 1; tick(); pc_inc = 0;
        peek("pc_inc", 2'd3, 2'd2, 8'h41);

        // Three-cycle read at MAR=0x10 with strobes pulsed while busy.
        load_rf(3, 8'h10);
        bus_sel = 2'd1; out_sel = 2'd3; mar_load = 1; tick(); mar_load = 0;
        mem_rd = 1; tick(); mem_rd = 0;
        check("rd_c1_busy", busy, 1);
        check("rd_c1_req", mem_req, 1);
        check("rd_c1_addr", mem_addr, 8'h10);
        check("rd_c1_we", mem_we, 0);
        bus_sel = 2'd3; rf_wsel = 2'd3; rf_we = 1; pc_inc = 1; tick(); rf_we = 0; pc_inc = 0;
        check("rd_c2_busy", busy, 1);
        check("rd_c2_addr", mem_addr, 8'h10);
        bus_sel = 2'd2; ir_load = 1; mar_load = 1; tick(); ir_load = 0; mar_load = 0;
        check("rd_c3_req", mem_req, 1);
        check("rd_c3_addr", mem_addr, 8'h10);
        mem_ack = 1; mem_rdata = 8'hA5; tick(); mem_ack = 0;
        check("rd_done_busy", busy, 0);
        check("rd_done_req", mem_req, 0);
        check("busy_ir_held", ir, 8'h41);
        peek("busy_rf_held", 2'd1, 2'd3, 8'h10);
        peek("busy_pc_held", 2'd3, 2'd3, 8'h41);
        peek("rd_mdr", 2'd2, 2'd3, 8'hA5);

        // Ack while idle is ignored.
        mem_ack = 1; mem_rdata = 8'h77; tick(); mem_ack = 0;
        check("idle_ack_busy", busy, 0);
        peek("idle_ack_mdr", 2'd2, 2'd3, 8'hA5);

        // rd+wr together performs a write and leaves MDR alone.
        load_rf(1, 8'h3C);
        mem_read(8'h5A);
        out_sel = 2'd1; mem_rd = 1; mem_wr = 1; tick(); mem_rd = 0; mem_wr = 0;
        check("wr_busy", busy, 1);
        check("wr_we", mem_we, 1);
        check("wr_wdata", mem_wdata, 8'h3C);
        check("wr_addr", mem_addr, 8'h10);
        mem_ack = 1; mem_rdata = 8'hEE; tick(); mem_ack = 0;
        check("wr_done_busy", busy, 0);
        peek("wr_mdr_kept", 2'd2, 2'd1, 8'h5A);

        // Reset mid-access aborts immediately; later ack is ignored.
        mem_rd = 1; tick(); mem_rd = 0;
        check("abort_pre_busy", busy, 1);
        reset = 1; #1;
        check("abort_req", mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", mem_addr, 0);
        #1 reset = 0;
        mem_ack = 1; mem_rdata = 8'h99; tick(); mem_ack = 0;
        check("abort_ack_busy", busy, 0);
        peek("abort_mdr", 2'd2, 2'd0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
